// File: rtl/isqrt_sum3_collector_pkg.sv
// ---------------------------------------------------------------------------
// isqrt_sum3_collector_pkg
// Shared widths and types for the square-root triple-sum collector.
//   Y_W          : width of one square-root result
//   RES_W        : width of a sum of three results (no overflow possible)
//   coll_state_t : collection FSM state (how many results of the current
//                  triple have been absorbed)
// ---------------------------------------------------------------------------
package isqrt_sum3_collector_pkg;

   localparam int Y_W   = 16;
   localparam int RES_W = 18;

   typedef enum logic [1:0] {
      S0,
      S1,
      S2
   } coll_state_t;

endpackage

// File: rtl/isqrt_sum3_collector_if.sv
// ---------------------------------------------------------------------------
// isqrt_sum3_collector_if
// Groups the collector's upstream credit/result signals and its downstream
// valid/ready result port.
//   launch / launch_rdy : upstream triple launch and credit available
//   y_vld / y           : square-root result stream (no backpressure)
//   res_vld / res_rdy   : sum handshake
//   res                 : sum of three results
//   err                 : sticky protocol-violation flag
// Modports: slave = the collector, master = its environment.
// ---------------------------------------------------------------------------
interface isqrt_sum3_collector_if;
   import isqrt_sum3_collector_pkg::*;

   logic             launch;
   logic             launch_rdy;
   logic             y_vld;
   logic [Y_W-1:0]   y;
   logic             res_vld;
   logic             res_rdy;
   logic [RES_W-1:0] res;
   logic             err;

   modport slave (
      input  launch, y_vld, y, res_rdy,
      output launch_rdy, res_vld, res, err
   );

   modport master (
      output launch, y_vld, y, res_rdy,
      input  launch_rdy, res_vld, res, err
   );

endinterface

// File: rtl/isqrt_sum3_collector_ff_fifo.sv
// ---------------------------------------------------------------------------
// ff_fifo
// Flip-flop FIFO with a combinational head read.
//   clk, rst : clock, synchronous active-low reset (empties the FIFO)
//   push     : write wdata (accepted when not full, or when popping as well)
//   pop      : drop the head entry (ignored when empty)
//   rdata    : current head entry
//   full, empty, count : occupancy status
// Pointers carry one extra bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module ff_fifo #(
   parameter int width = 18,
   parameter int depth = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [width-1:0]       wdata,
   output logic [width-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(depth):0] count
);

   localparam int AW = $clog2(depth);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [width-1:0] w_entries [depth];
   logic             w_wr_en;
   logic             w_rd_en;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign count = r_wr_ptr - r_rd_ptr;

   assign w_rd_en = pop && !empty;
   // A simultaneous pop frees the head slot, so a push into a full FIFO is
   // still accepted in that case.
   assign w_wr_en = push && (!full || w_rd_en);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   for (genvar gi = 0; gi < depth; gi++) begin : g_entry
      logic [width-1:0] r_entry;

      always_ff @(posedge clk) begin
         if (w_wr_en && (r_wr_ptr[AW-1:0] == AW'(gi))) r_entry <= wdata;
      end

      assign w_entries[gi] = r_entry;
   end

   assign rdata = w_entries[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/isqrt_sum3_collector.sv
// ---------------------------------------------------------------------------
// isqrt_sum3_collector
// Groups every three consecutive square-root results into one sum, buffers
// the sums in a FIFO and hands out launch credits so the non-stallable
// square-root pipe can never overrun the buffer.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : isqrt_sum3_collector_if.slave (launch/credit, results, sums, err)
// Parameter fifo_depth: number of buffered sums (power of two, >= 2).
// ---------------------------------------------------------------------------
module isqrt_sum3_collector
   import isqrt_sum3_collector_pkg::*;
#(
   parameter int fifo_depth = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   isqrt_sum3_collector_if.slave bus
);

   localparam int CNT_W = $clog2(fifo_depth) + 1;
   localparam int SUM_W = CNT_W + 1;

   coll_state_t      r_state;
   coll_state_t      w_state_next;
   logic [RES_W-1:0] r_acc;
   logic [RES_W-1:0] w_acc_next;
   logic [RES_W-1:0] w_push_data;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [RES_W-1:0] w_head;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] r_reserved;
   logic [SUM_W-1:0] w_credit_used;
   logic             w_launch_rdy;
   logic             w_launch_ok;
   logic             w_res_dec;
   logic             w_err_evt;
   logic             r_err;

   // ---------------- collection FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S0;
         r_acc   <= '0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_push       = 1'b0;
      w_push_data  = r_acc + RES_W'(bus.y);
      if (bus.y_vld) begin
         case (r_state)
            S0: begin
               w_acc_next   = RES_W'(bus.y);
               w_state_next = S1;
            end
            S1: begin
               w_acc_next   = r_acc + RES_W'(bus.y);
               w_state_next = S2;
            end
            S2: begin
               w_push       = 1'b1;
               w_acc_next   = '0;
               w_state_next = S0;
            end
            default: begin
               w_acc_next   = '0;
               w_state_next = S0;
            end
         endcase
      end
   end

   // ---------------- credit accounting ----------------
   // A credit is held from launch until the triple lands in the FIFO, and
   // then by the FIFO entry until it is popped; occupancy + reserved can
   // therefore never exceed the FIFO depth.
   assign w_credit_used = SUM_W'(w_count) + SUM_W'(r_reserved);
   assign w_launch_rdy  = rst && (w_credit_used < SUM_W'(fifo_depth));
   assign w_launch_ok   = bus.launch && w_launch_rdy;
   // A triple completed without a matching launch has no credit to return.
   assign w_res_dec     = w_push && (r_reserved != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_reserved <= '0;
      end else if (w_launch_ok && !w_res_dec) begin
         r_reserved <= r_reserved + 1'b1;
      end else if (!w_launch_ok && w_res_dec) begin
         r_reserved <= r_reserved - 1'b1;
      end
   end

   // ---------------- sticky error ----------------
   assign w_err_evt = (bus.launch && !w_launch_rdy) ||
                      (bus.y_vld && (r_reserved == '0)) ||
                      (w_push && w_full && !w_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_err_evt) begin
         r_err <= 1'b1;
      end
   end

   // ---------------- sum buffer ----------------
   assign w_pop = !w_empty && bus.res_rdy;

   ff_fifo #(
      .width (RES_W),
      .depth (fifo_depth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (w_push_data),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   assign bus.launch_rdy = w_launch_rdy;
   assign bus.res_vld    = !w_empty;
   assign bus.res        = w_empty ? '0 : w_head;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_isqrt_sum3_collector.sv
// ---------------------------------------------------------------------------
// tb_isqrt_sum3_collector
// Cycle-driven bench: each step checks the DUT outputs against a queue-based
// reference model, then drives the next inputs and advances the model.
// ---------------------------------------------------------------------------
module tb_isqrt_sum3_collector;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   isqrt_sum3_collector_if bus ();

   isqrt_sum3_collector #(
      .fifo_depth (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_q[$];        // buffered sums, head first
   int m_res   = 0;   // launched triples not yet buffered
   int m_acc   = 0;   // partial sum of current triple
   int m_n     = 0;   // results seen in current triple
   bit m_err   = 0;
   bit cur_rst = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic bit model_rdy();
      return (m_q.size() + m_res) < DEPTH;
   endfunction

   task automatic model_update(input bit l, input bit yv, input int yy, input bit rr, input bit rs);
      bit ok, pop, push, dec;
      int sum;
      if (!rs) begin
         m_q.delete();
         m_res = 0; m_acc = 0; m_n = 0; m_err = 0;
         return;
      end
      pop  = (m_q.size() > 0) && rr;
      ok   = l && model_rdy();
      if (l && !ok) m_err = 1;
      push = 0;
      sum  = 0;
      if (yv) begin
         if (m_res == 0) m_err = 1;
         m_acc += yy;
         m_n++;
         if (m_n == 3) begin
            push = 1; sum = m_acc; m_acc = 0; m_n = 0;
         end
      end
      if (pop) $display("pop res=%0d", m_q.pop_front());
      if (push) begin
         if (m_q.size() == DEPTH) m_err = 1;
         else m_q.push_back(sum);
      end
      dec = push && (m_res > 0);
      m_res = m_res + int'(ok) - int'(dec);
   endtask

   task automatic step(input bit l, input bit yv, input logic [15:0] yy, input bit rr, input bit rs);
      bit exp_vld;
      int exp_res;
      @(negedge clk);
      exp_vld = m_q.size() > 0;
      exp_res = exp_vld ? m_q[0] : 0;
      check_val("res_vld", 32'(bus.res_vld), 32'(exp_vld));
      check_val("res", 32'(bus.res), exp_res);
      check_val("launch_rdy", 32'(bus.launch_rdy), 32'(cur_rst && model_rdy()));
      check_val("err", 32'(bus.err), 32'(m_err));
      bus.launch  = l;
      bus.y_vld   = yv;
      bus.y       = yy;
      bus.res_rdy = rr;
      rst         = rs;
      cur_rst     = rs;
      model_update(l, yv, int'(yy), rr, rs);
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) step(0, 0, 16'd0, rr, 1);
   endtask

   // checks the state committed by the next clock edge
   task automatic probe(input string tag, input logic [31:0] obs_sel, input logic [31:0] exp);
      @(posedge clk);
      #1;
      case (obs_sel)
         0: check_val(tag, 32'(bus.res), exp);
         1: check_val(tag, 32'(bus.res_vld), exp);
         2: check_val(tag, 32'(bus.launch_rdy), exp);
         default: check_val(tag, 32'(bus.err), exp);
      endcase
   endtask

   initial begin
      int pend;
      bit l, yv, rr;
      logic [15:0] yr;

      clk = 0; rst = 0;
      bus.launch = 0; bus.y_vld = 0; bus.y = '0; bus.res_rdy = 0;
      repeat (2) @(negedge clk);
      step(0, 0, 16'd0, 0, 0);
      step(0, 0, 16'd0, 0, 1);

      // single triple 3,4,5
      step(1, 0, 16'd0, 1, 1);
      step(0, 1, 16'd3, 1, 1);
      step(0, 1, 16'd4, 1, 1);
      step(0, 1, 16'd5, 1, 1);
      probe("single_res", 0, 12);
      idle(3, 1);

      // max values with two idle cycles between results
      step(1, 0, 16'd0, 1, 1);
      step(0, 1, 16'hFFFF, 1, 1);
      idle(2, 1);
      step(0, 1, 16'hFFFF, 1, 1);
      idle(2, 1);
      step(0, 1, 16'hFFFF, 1, 1);
      probe("max_res", 0, 196605);
      idle(3, 1);

      // randomized well-behaved traffic
      pend = 0;
      for (int c = 0; c < 1500; c++) begin
         l  = model_rdy() && ($urandom_range(0, 2) == 0);
         yv = (pend > 0) && ($urandom_range(0, 1) == 1);
         yr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         rr = $urandom_range(0, 3) != 0;
         step(l, yv, yr, rr, 1);
         if (yv) pend--;
         if (l) pend += 3;
      end
      while (pend > 0) begin
         step(0, 1, 16'($urandom), 1, 1);
         pend--;
      end
      idle(DEPTH + 2, 1);
      probe("clean_err", 3, 0);

      // backpressure: four credits, fifth launch rejected
      for (int i = 0; i < DEPTH; i++) step(1, 0, 16'd0, 0, 1);
      probe("bp_rdy_low", 2, 0);
      step(1, 0, 16'd0, 0, 1);
      probe("bp_err", 3, 1);
      for (int i = 0; i < 3 * DEPTH; i++) step(0, 1, 16'(100 + i), 0, 1);
      step(0, 0, 16'd0, 1, 1);
      probe("bp_rdy_back", 2, 1);
      idle(DEPTH + 2, 1);

      // reset clears err; then spurious results set it for good
      step(0, 0, 16'd0, 1, 0);
      probe("rst_err", 3, 0);
      step(0, 1, 16'd7, 1, 1);
      probe("spur_err", 3, 1);
      step(0, 1, 16'd8, 1, 1);
      step(0, 1, 16'd9, 1, 1);
      idle(2, 1);
      step(1, 0, 16'd0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 16'(20 + i), 1, 1);
      idle(3, 1);
      probe("spur_sticky", 3, 1);

      // reset mid-operation with two sums buffered and a partial triple
      step(0, 0, 16'd0, 1, 0);
      step(0, 0, 16'd0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 16'd0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 1, 16'(50 + i), 0, 1);
      step(0, 0, 16'd0, 0, 0);
      probe("mid_rst_vld", 1, 0);
      check_val("mid_rst_res", 32'(bus.res), 0);
      check_val("mid_rst_rdy", 32'(bus.launch_rdy), 0);
      step(1, 0, 16'd0, 1, 1);
      step(0, 1, 16'd1, 1, 1);
      step(0, 1, 16'd1, 1, 1);
      step(0, 1, 16'd1, 1, 1);
      probe("fresh_res", 0, 3);
      idle(3, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
